fpu_share_arb: RTL

Round-robin arbiter and response router that shares one single-precision `fpu_core` between `NUM_REQ` requesters, typically the cores of a cluster. Each cycle it grants at most one request and drives that request onto the FPU input port. It tracks the in-flight operation with a tag pipeline and returns the registered result, per-op flags and per-requester sticky exception flags. Opcodes the datapath does not implement are answered locally with an invalid-operation response and are never issued to the FPU.

---
 rtl/fpu_share_arb_if.sv | 51 +++++
 rtl/fpu_share_arb.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fpu_share_arb_if.sv
// Bundle of requester-side and FPU-side signals of the shared-FPU arbiter.
// The arbiter uses the slave view; requesters and the FPU use the master view.
interface fpu_share_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int C_OP    = 32,
  parameter int C_CMD   = 4,
  parameter int C_RM    = 2,
  parameter int C_FLAGS = 6
);
  logic [NUM_REQ-1:0]         Req_SI;
  logic [NUM_REQ*C_OP-1:0]    Operand_a_DI;
  logic [NUM_REQ*C_OP-1:0]    Operand_b_DI;
  logic [NUM_REQ*C_RM-1:0]    RM_SI;
  logic [NUM_REQ*C_CMD-1:0]   OP_SI;
  logic [NUM_REQ-1:0]         Gnt_SO;
  logic [NUM_REQ-1:0]         Rvalid_SO;
  logic [C_OP-1:0]            Result_DO;
  logic [C_FLAGS-1:0]         Flags_DO;
  logic [NUM_REQ-1:0]         Clear_SI;
  logic [NUM_REQ*C_FLAGS-1:0] Fflags_DO;

  logic                       Fpu_Enable_SO;
  logic [C_OP-1:0]            Fpu_Operand_a_DO;
  logic [C_OP-1:0]            Fpu_Operand_b_DO;
  logic [C_RM-1:0]            Fpu_RM_SO;
  logic [C_CMD-1:0]           Fpu_OP_SO;
  logic [C_OP-1:0]            Fpu_Result_DI;
  logic                       Fpu_Valid_SI;
  logic                       Fpu_OF_SI;
  logic                       Fpu_UF_SI;
  logic                       Fpu_Zero_SI;
  logic                       Fpu_IX_SI;
  logic                       Fpu_IV_SI;
  logic                       Fpu_Inf_SI;

  modport slave (
    input  Req_SI, Operand_a_DI, Operand_b_DI, RM_SI, OP_SI, Clear_SI,
    input  Fpu_Result_DI, Fpu_Valid_SI, Fpu_OF_SI, Fpu_UF_SI, Fpu_Zero_SI,
    input  Fpu_IX_SI, Fpu_IV_SI, Fpu_Inf_SI,
    output Gnt_SO, Rvalid_SO, Result_DO, Flags_DO, Fflags_DO,
    output Fpu_Enable_SO, Fpu_Operand_a_DO, Fpu_Operand_b_DO, Fpu_RM_SO, Fpu_OP_SO
  );

  modport master (
    output Req_SI, Operand_a_DI, Operand_b_DI, RM_SI, OP_SI, Clear_SI,
    output Fpu_Result_DI, Fpu_Valid_SI, Fpu_OF_SI, Fpu_UF_SI, Fpu_Zero_SI,
    output Fpu_IX_SI, Fpu_IV_SI, Fpu_Inf_SI,
    input  Gnt_SO, Rvalid_SO, Result_DO, Flags_DO, Fflags_DO,
    input  Fpu_Enable_SO, Fpu_Operand_a_DO, Fpu_Operand_b_DO, Fpu_RM_SO, Fpu_OP_SO
  );
endinterface

// File: rtl/fpu_share_arb.sv
// Round-robin sharing of one single-precision FPU between NUM_REQ requesters,
// with a tag pipeline routing each result back and per-requester sticky flags.
module fpu_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int C_OP    = 32,
  parameter int C_CMD   = 4,
  parameter int C_RM    = 2,
  parameter int C_FLAGS = 6
) (
  input logic           Clk_CI,
  input logic           Rst_RBI,
  fpu_share_arb_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]         ptr, ptr_next, win, t_idx;
  logic                     found, legal, issue;
  logic                     t_valid, t_ill;
  int                       cand;
  logic [C_OP-1:0]          resp_result, result_q;
  logic [C_FLAGS-1:0]       resp_flags, flags_q;
  logic [NUM_REQ-1:0]       rvalid_q;
  logic [NUM_REQ*C_FLAGS-1:0] sticky_q;

  function automatic logic is_legal(input logic [C_CMD-1:0] op);
    case (op)
      C_CMD'(0), C_CMD'(1), C_CMD'(2), C_CMD'(4), C_CMD'(5): return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Search upward from the pointer with wrap-around; first requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && bus.Req_SI[cand]) begin
        found = 1'b1;
        win   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    bus.Gnt_SO = '0;
    if (found) bus.Gnt_SO[win] = 1'b1;
  end

  assign legal    = is_legal(bus.OP_SI[win*C_CMD +: C_CMD]);
  assign issue    = found && legal;
  assign ptr_next = (win == IDX_W'(NUM_REQ-1)) ? '0 : win + 1'b1;

  // Illegal or absent grants keep the FPU idle with zeroed inputs.
  always_comb begin
    bus.Fpu_Enable_SO    = 1'b0;
    bus.Fpu_Operand_a_DO = '0;
    bus.Fpu_Operand_b_DO = '0;
    bus.Fpu_RM_SO        = '0;
    bus.Fpu_OP_SO        = '0;
    if (issue) begin
      bus.Fpu_Enable_SO    = 1'b1;
      bus.Fpu_Operand_a_DO = bus.Operand_a_DI[win*C_OP +: C_OP];
      bus.Fpu_Operand_b_DO = bus.Operand_b_DI[win*C_OP +: C_OP];
      bus.Fpu_RM_SO        = bus.RM_SI[win*C_RM +: C_RM];
      bus.Fpu_OP_SO        = bus.OP_SI[win*C_CMD +: C_CMD];
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      ptr     <= '0;
      t_valid <= 1'b0;
      t_idx   <= '0;
      t_ill   <= 1'b0;
    end else begin
      if (found) ptr <= ptr_next;
      t_valid <= found;
      t_idx   <= win;
      t_ill   <= !legal;
    end
  end

  // Illegal ops get a locally generated quiet NaN with only IV raised.
  always_comb begin
    resp_result = bus.Fpu_Result_DI;
    resp_flags  = C_FLAGS'({bus.Fpu_Inf_SI, bus.Fpu_IV_SI, bus.Fpu_IX_SI,
                            bus.Fpu_Zero_SI, bus.Fpu_UF_SI, bus.Fpu_OF_SI});
    if (t_ill) begin
      resp_result = C_OP'(32'h7FC0_0000);
      resp_flags  = C_FLAGS'(6'b010000);
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      rvalid_q <= '0;
      result_q <= '0;
      flags_q  <= '0;
      sticky_q <= '0;
    end else begin
      rvalid_q <= t_valid ? (NUM_REQ'(1) << t_idx) : '0;
      if (t_valid) begin
        result_q <= resp_result;
        flags_q  <= resp_flags;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        sticky_q[i*C_FLAGS +: C_FLAGS] <=
          (bus.Clear_SI[i] ? '0 : sticky_q[i*C_FLAGS +: C_FLAGS]) |
          ((t_valid && t_idx == IDX_W'(i)) ? resp_flags : '0);
      end
    end
  end

  assign bus.Rvalid_SO = rvalid_q;
  assign bus.Result_DO = result_q;
  assign bus.Flags_DO  = flags_q;
  assign bus.Fflags_DO = sticky_q;

  // The FPU must answer every issued op one cycle after the grant.
  fpu_valid_missing: assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
    !(t_valid && !t_ill && !bus.Fpu_Valid_SI));
endmodule
